mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Multiply/divide responder for the 5-stage MIPS pipeline, instantiated beside the ALU in the E stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests issued from E.
- Models the multi-cycle latency with a busy handshake, which the hazard unit consumes to stall md-class instructions in D.
- Holds the architectural HI/LO registers that MFHI/MFLO read.

Parameters:
MUL_CYCLES, 5, busy duration in cycles for MULT/MULTU
DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op_valid  input  1  E-stage md request strobe, one cycle per instruction
md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved
a  input  32  forwarded rs value from E
b  input  32  forwarded rt value from E
busy  output  1  operation in progress; hazard unit stalls md instructions while (op_valid && md_op<=3) || busy
hi  output  32  HI register (registered)
lo  output  32  LO register (registered)

Behaviour:
- Reset (synchronous, reset=1 at rising edge): hi=0, lo=0, busy=0, counter=0, state=IDLE. Reset overrides every other input.
- States: IDLE, BUSY.
- Reset mid-operation: aborts the operation, pending result discarded, hi/lo cleared.
- IDLE, op_valid=1, md_op in 0..3:
  - At the edge, compute the result and latch it into pending_hi/pending_lo.
  - Load counter with MUL_CYCLES or DIV_CYCLES; go to BUSY.
  - busy=1 starting the cycle after the issue edge.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter reaches 0: hi/lo take pending values, busy falls, state returns to IDLE.
  - busy is high for exactly MUL_CYCLES / DIV_CYCLES consecutive cycles.
  - hi/lo keep old values until that edge.
- MTHI/MTLO in IDLE: hi (or lo) = a at the next edge; busy stays 0; the other register is unchanged.
- op_valid while BUSY (any md_op): ignored. The hazard unit prevents it; the bench checks that it causes no state change.
- Reserved md_op (6/7) with op_valid: ignored.
- Arithmetic:
  - MULT: signed 32x32 to 64-bit product; hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32 to 64-bit product.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
  - Divide by zero (DIV or DIVU): full busy period is still taken; hi/lo stay unchanged at completion.
- Completion and new issue never coincide: the unit is still BUSY on the completion edge, so a new issue is accepted from the following cycle.
- MFHI/MFLO reads are not part of this block. The datapath muxes hi/lo directly, and the hazard unit stalls them while busy.

Decomposition:
- Shared package md_defs:
  - md_op encodings (MD_MULT..MD_MTLO)
  - default MUL_CYCLES/DIV_CYCLES constants
  - helper predicate is_md_start(op) for ops 0..3, used by both this block and the hazard unit.
- Single module; the FSM plus counter is small.
- Sub-module md_div_core is permitted: combinational signed/unsigned quotient/remainder with the zero-divisor and overflow rules isolated, so it can be unit-tested alone.

Test Plan:
1. Reset: assert reset 2 cycles -> busy=0, hi=0x00000000, lo=0x00000000.
2. MULT a=0xFFFFFFFE, b=0x00000003 -> busy high cycles 1..5 after issue; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
3. DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> busy exactly 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Preload hi=0x11111111 and lo=0x22222222 via MTHI/MTLO, then DIVU a=7, b=0 -> busy 10 cycles; hi/lo unchanged.
5. MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, lo unchanged, busy never asserted. During a MULT busy period, pulse op_valid with MTLO a=0xDEADBEEF -> ignored; final lo equals the MULT result.
6. Issue DIV, assert reset in busy cycle 3 -> next cycle busy=0, hi=lo=0, and no later write occurs. A new MULT issued afterwards completes normally.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions: opcode encodings, default latencies and
// the start predicate used by both this unit and the hazard unit.
package md_defs;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } md_state_e;

    localparam int unsigned MUL_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF = 10;

    // True for the four multi-cycle ops that occupy the unit.
    function automatic logic is_md_start(input logic [2:0] op);
        return op <= 3'd3;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage request bundle and HI/LO/busy response of the multiply/divide unit.
interface mult_div_unit_if;
    logic        op_valid;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output op_valid, md_op, a, b, input busy, hi, lo);
    modport slave  (input op_valid, md_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit_div_core.sv
// Combinational 32-bit signed/unsigned divider with the zero-divisor and
// INT_MIN / -1 overflow rules kept in one place.
module md_div_core (
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        signed_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        divByZero_o
);

    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] safeB;
    logic [31:0] uQuot;
    logic [31:0] uRem;

    // Divide magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend.
    always_comb begin
        negA        = signed_i & dividend_i[31];
        negB        = signed_i & divisor_i[31];
        magA        = negA ? (32'd0 - dividend_i) : dividend_i;
        magB        = negB ? (32'd0 - divisor_i) : divisor_i;
        divByZero_o = (divisor_i == 32'd0);
        safeB       = divByZero_o ? 32'd1 : magB;
        uQuot       = magA / safeB;
        uRem        = magA % safeB;
        quotient_o  = 32'd0;
        remainder_o = 32'd0;
        if (divByZero_o) begin
            quotient_o  = 32'd0;
            remainder_o = 32'd0;
        end else if (signed_i && dividend_i == 32'h8000_0000 && divisor_i == 32'hFFFF_FFFF) begin
            quotient_o  = 32'h8000_0000;
            remainder_o = 32'd0;
        end else begin
            quotient_o  = (negA ^ negB) ? (32'd0 - uQuot) : uQuot;
            remainder_o = negA ? (32'd0 - uRem) : uRem;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS E-stage multiply/divide unit: holds HI/LO and models multi-cycle
// latency with a busy flag consumed by the hazard unit.
module mult_div_unit
    import md_defs::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    md_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pendHi_q, pendHi_d;
    logic [31:0] pendLo_q, pendLo_d;
    logic        pendWr_q, pendWr_d;

    logic [63:0] prodSigned;
    logic [63:0] prodUnsigned;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divByZero;

    md_div_core u_div_core (
        .dividend_i  (md.a),
        .divisor_i   (md.b),
        .signed_i    (md.md_op == MD_DIV),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .divByZero_o (divByZero)
    );

    always_comb begin
        prodSigned   = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
        prodUnsigned = {32'd0, md.a} * {32'd0, md.b};
    end

    // The result is computed at issue; HI/LO only change when the counter expires,
    // and a zero divisor simply leaves them untouched at that point.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        pendHi_d = pendHi_q;
        pendLo_d = pendLo_q;
        pendWr_d = pendWr_q;
        case (state_q)
            ST_IDLE: begin
                if (md.op_valid) begin
                    case (md.md_op)
                        MD_MULT: begin
                            pendHi_d = prodSigned[63:32];
                            pendLo_d = prodSigned[31:0];
                            pendWr_d = 1'b1;
                        end
                        MD_MULTU: begin
                            pendHi_d = prodUnsigned[63:32];
                            pendLo_d = prodUnsigned[31:0];
                            pendWr_d = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            pendHi_d = remainder;
                            pendLo_d = quotient;
                            pendWr_d = !divByZero;
                        end
                        MD_MTHI: hi_d = md.a;
                        MD_MTLO: lo_d = md.a;
                        default: ;
                    endcase
                    if (is_md_start(md.md_op)) begin
                        state_d = ST_BUSY;
                        cnt_d   = (md.md_op == MD_DIV || md.md_op == MD_DIVU) ?
                                  CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (pendWr_q) begin
                        hi_d = pendHi_q;
                        lo_d = pendLo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            pendHi_q <= 32'd0;
            pendLo_q <= 32'd0;
            pendWr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pendHi_q <= pendHi_d;
            pendLo_q <= pendLo_d;
            pendWr_q <= pendWr_d;
        end
    end

    assign md.busy = (state_q == ST_BUSY);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed scenarios with literal expectations plus a
// randomized run, all checked each cycle against a transaction-level model.
module tb_mult_div_unit;
    import md_defs::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic checkEn = 1'b0;

    mult_div_unit_if mdIf ();

    mult_div_unit #(.MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdIf.slave)
    );

    always #5 clk = ~clk;

    // Architectural result of one request: {write-enable, hi, lo}.
    function automatic logic [64:0] mdResult(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      p;
        logic [63:0] pu;
        int          sq;
        int          sr;
        case (op)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return {1'b1, 64'(p)};
            end
            3'd1: begin
                pu = {32'd0, x} * {32'd0, y};
                return {1'b1, pu};
            end
            3'd2: begin
                if (y == 32'd0) return 65'd0;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b1, 32'h0, 32'h8000_0000};
                sq = $signed(x) / $signed(y);
                sr = $signed(x) % $signed(y);
                return {1'b1, 32'(sr), 32'(sq)};
            end
            3'd3: begin
                if (y == 32'd0) return 65'd0;
                return {1'b1, x % y, x / y};
            end
            default: return 65'd0;
        endcase
    endfunction

    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    logic [31:0] mPendHi = 32'd0;
    logic [31:0] mPendLo = 32'd0;
    logic        mPendValid = 1'b0;
    int          mLeft = 0;
    logic [64:0] mRes;

    always_comb mRes = mdResult(mdIf.md_op, mdIf.a, mdIf.b);

    // Model: remaining busy cycles plus a pending result applied when they run out.
    always @(posedge clk) begin
        if (reset) begin
            mHi   <= 32'd0;
            mLo   <= 32'd0;
            mLeft <= 0;
        end else if (mLeft > 0) begin
            if (mLeft == 1 && mPendValid) begin
                mHi <= mPendHi;
                mLo <= mPendLo;
            end
            mLeft <= mLeft - 1;
        end else if (mdIf.op_valid) begin
            if (mdIf.md_op <= 3'd3) begin
                mPendValid <= mRes[64];
                mPendHi    <= mRes[63:32];
                mPendLo    <= mRes[31:0];
                mLeft      <= (mdIf.md_op <= 3'd1) ? MUL_LAT : DIV_LAT;
            end else if (mdIf.md_op == 3'd4) begin
                mHi <= mdIf.a;
            end else if (mdIf.md_op == 3'd5) begin
                mLo <= mdIf.a;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request for a single cycle; returns just after the issue edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        mdIf.op_valid = 1'b1;
        mdIf.md_op    = op;
        mdIf.a        = x;
        mdIf.b        = y;
        @(posedge clk);
        #1;
        mdIf.op_valid = 1'b0;
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (mdIf.busy === 1'b1 && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (n >= 50) checkOutput("busy_timeout", 32'(n), 32'd0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mainSequence();
        int n;
        reset         = 1'b1;
        mdIf.op_valid = 1'b0;
        mdIf.md_op    = 3'd0;
        mdIf.a        = 32'd0;
        mdIf.b        = 32'd0;
        idleCycles(2);
        reset   = 1'b0;
        checkEn = 1'b1;
        checkOutput("reset_busy", 32'(mdIf.busy), 32'd0);
        checkOutput("reset_hi", mdIf.hi, 32'h0);
        checkOutput("reset_lo", mdIf.lo, 32'h0);

        applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        countBusy(n);
        checkOutput("mult_busy_len", 32'(n), 32'd5);
        checkOutput("mult_hi", mdIf.hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", mdIf.lo, 32'hFFFF_FFFA);
        applyStimulus(MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
        countBusy(n);
        checkOutput("multu_hi", mdIf.hi, 32'h0000_0002);
        checkOutput("multu_lo", mdIf.lo, 32'hFFFF_FFFA);

        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        countBusy(n);
        checkOutput("div_busy_len", 32'(n), 32'd10);
        checkOutput("div_lo", mdIf.lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", mdIf.hi, 32'hFFFF_FFFF);
        applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        countBusy(n);
        checkOutput("divovf_lo", mdIf.lo, 32'h8000_0000);
        checkOutput("divovf_hi", mdIf.hi, 32'h0);

        applyStimulus(MD_MTHI, 32'h1111_1111, 32'h0);
        applyStimulus(MD_MTLO, 32'h2222_2222, 32'h0);
        applyStimulus(MD_DIVU, 32'd7, 32'd0);
        countBusy(n);
        checkOutput("divz_busy_len", 32'(n), 32'd10);
        checkOutput("divz_hi", mdIf.hi, 32'h1111_1111);
        checkOutput("divz_lo", mdIf.lo, 32'h2222_2222);

        applyStimulus(MD_MTHI, 32'h1234_5678, 32'h0);
        checkOutput("mthi_busy", 32'(mdIf.busy), 32'd0);
        checkOutput("mthi_hi", mdIf.hi, 32'h1234_5678);
        checkOutput("mthi_lo", mdIf.lo, 32'h2222_2222);
        applyStimulus(MD_MULT, 32'h0001_0000, 32'h0001_0000);
        idleCycles(1);
        applyStimulus(MD_MTLO, 32'hDEAD_BEEF, 32'h0);
        countBusy(n);
        checkOutput("ignored_hi", mdIf.hi, 32'h0000_0001);
        checkOutput("ignored_lo", mdIf.lo, 32'h0000_0000);

        applyStimulus(MD_DIV, 32'd100, 32'd7);
        idleCycles(2);
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        checkOutput("abort_busy", 32'(mdIf.busy), 32'd0);
        checkOutput("abort_hi", mdIf.hi, 32'h0);
        checkOutput("abort_lo", mdIf.lo, 32'h0);
        idleCycles(12);
        checkOutput("abort_late_hi", mdIf.hi, 32'h0);
        checkOutput("abort_late_lo", mdIf.lo, 32'h0);
        applyStimulus(MD_MULT, 32'd3, 32'd4);
        countBusy(n);
        checkOutput("after_abort_len", 32'(n), 32'd5);
        checkOutput("after_abort_lo", mdIf.lo, 32'd12);

        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 149) == 0);
            mdIf.op_valid = ($urandom_range(0, 2) == 0);
            mdIf.md_op    = 3'($urandom_range(0, 7));
            mdIf.a        = $urandom;
            case ($urandom_range(0, 9))
                0: mdIf.b = 32'd0;
                1: begin
                    mdIf.a = 32'h8000_0000;
                    mdIf.b = 32'hFFFF_FFFF;
                end
                2, 3: mdIf.b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF);
                default: mdIf.b = $urandom;
            endcase
            idleCycles(1);
        end
        reset         = 1'b0;
        mdIf.op_valid = 1'b0;
        idleCycles(DIV_LAT + 2);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (checkEn) begin
                        checkOutput("model_busy", 32'(mdIf.busy), 32'(mLeft > 0));
                        checkOutput("model_hi", mdIf.hi, mHi);
                        checkOutput("model_lo", mdIf.lo, mLo);
                    end
                end
            end
            mainSequence();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
